adc_lane_aligner: RTL and testbench
===================================

ADC_LANE_ALIGNER -- requirements
Module: adc_lane_aligner

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of 2-lane ADC channels (1..8).
REQ-002 SHALL have parameter RES, default 14, sample resolution (14 or 16 only).
REQ-003 SHALL have parameter FRAME_PATTERN, default 8'hF0, expected deserialized frame-clock word.
REQ-004 SHALL have parameter SETTLE_CYC, default 4, cycles waited after each bitslip pulse (1..15).
REQ-005 SHALL have parameter LOCK_CNT, default 8, consecutive matches required to declare lock (1..255).
REQ-006 SHALL have parameter UNLOCK_CNT, default 4, consecutive mismatches in lock that drop lock (1..255).
REQ-007 SHALL have parameter MAX_SLIPS, default 8, slips per search pass before align_fail (1..15).
REQ-008 SHALL have port CLKDIV  in  1  single clock; one clock, all logic on rising edge.
REQ-009 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have port en  in  1  enable; low forces IDLE.
REQ-011 SHALL have port frm_data  in  8  deserialized frame-clock word.
REQ-012 SHALL have port lane0_data  in  N_CH*8  even-bit lane words, channel c at [c*8+:8].
REQ-013 SHALL have port lane1_data  in  N_CH*8  odd-bit lane words, same packing.
REQ-014 SHALL have port bitslip  out  1  single-cycle slip pulse to all deserializers.
REQ-015 SHALL have port aligned  out  1  high only in LOCKED.
REQ-016 SHALL have port align_fail  out  1  sticky search-failure flag.
REQ-017 SHALL have port slip_count  out  4  slips issued in current search pass.
REQ-018 SHALL have port sample_o  out  N_CH*16  assembled samples, channel c at [c*16+:16].
REQ-019 SHALL have port sample_valid  out  1  sample_o qualifier.

Function
REQ-020 SHALL implement FSM states IDLE, CHECK, SLIP, SETTLE, LOCKED.
REQ-021 IDLE -> CHECK when en=1; no slip issued on entry.
REQ-022 CHECK: each cycle frm_data==FRAME_PATTERN increments match_cnt; at LOCK_CNT-th consecutive match -> LOCKED next cycle.
REQ-023 CHECK: mismatch clears match_cnt and -> SLIP.
REQ-024 SLIP: bitslip=1 for exactly one cycle, slip_count increments, -> SETTLE; bitslip SHALL never be high in any other state.
REQ-025 When slip_count reaches MAX_SLIPS, align_fail SHALL set and slip_count SHALL wrap to 0 same cycle; search continues.
REQ-026 SETTLE: wait SETTLE_CYC cycles ignoring frm_data, then -> CHECK with match_cnt=0.
REQ-027 LOCKED: mismatch increments miss_cnt, match clears it; UNLOCK_CNT-th consecutive mismatch -> CHECK, aligned low next cycle, slip_count=0.
REQ-028 en=0 in any state SHALL force IDLE next cycle and clear match_cnt, miss_cnt, slip_count, align_fail, aligned.
REQ-029 Each cycle sample_o SHALL register, per channel, RES=16: {l1[0],l0[0],l1[1],l0[1],...,l1[7],l0[7]}; RES=14: bits 0..6 pairs in [13:0], [15:14]=0.
REQ-030 sample_valid SHALL register (state==LOCKED); sample_o and sample_valid both have 1-cycle latency from inputs.
REQ-031 align_fail SHALL stay set through LOCKED until en=0 or RST.

Reset
REQ-032 RST SHALL asynchronously force IDLE and all outputs, counters and sample registers to 0.
REQ-033 RST mid-search or mid-lock SHALL abandon state; no bitslip pulse on release.

Structure
REQ-034 Package adc_pkg SHALL hold the FSM state enum, default FRAME_PATTERN and sample width constant (16).
REQ-035 SHALL instantiate N_CH copies of combinational sub-module adc_sample_pack (one channel bit interleave, RES param).

Verification
REQ-036 frm_data constant 8'hF0 after en=1 -> no bitslip, aligned high 9 cycles after en (8 checks + transition), slip_count 0.
REQ-037 frm_data 8'hE1 until second slip then 8'hF0 -> exactly 2 one-cycle bitslip pulses spaced 1+SETTLE_CYC+1 cycles, aligned then high.
REQ-038 frm_data never matches -> align_fail set after 8th slip, slip_count wraps 7->0, bitslip continues.
REQ-039 in LOCKED, 3 mismatches then match -> aligned stays high; 4 mismatches -> aligned low, state CHECK.
REQ-040 RES=16, N_CH=1, lane1=8'hFF, lane0=8'h00 -> sample_o=16'hAAAA one cycle later; RES=14 same inputs -> 16'h2AAA.
REQ-041 RST asserted while LOCKED -> aligned, sample_valid, sample_o zero immediately (asynchronous).

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC lane aligner: FSM state encoding,
// default frame-clock word and the fixed per-channel sample width.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4
    } state_t;

    localparam logic [7:0] FRAME_PATTERN_DEF = 8'hF0;
    localparam int         SAMPLE_W          = 16;

endpackage

// File: rtl/adc_sample_pack.sv
// Interleaves one channel's even/odd lane words into a sample, MSB first from bit 0.
// Purely combinational; RES=14 drops bit 7 of each lane and zero-fills the top two bits.
module adc_sample_pack
    import adc_pkg::*;
#(
    parameter int RES = 14
)(
    input  logic [7:0]          i_lane0,
    input  logic [7:0]          i_lane1,
    output logic [SAMPLE_W-1:0] o_sample
);

    localparam int NB = RES / 2;

    // Bit 7 of each lane only contributes at RES=16.
    logic w_unused;
    assign w_unused = i_lane0[7] ^ i_lane1[7];

    for (genvar i = 0; i < NB; i++) begin : g_bit
        assign o_sample[RES-1-2*i] = i_lane1[i];
        assign o_sample[RES-2-2*i] = i_lane0[i];
    end

    if (RES < SAMPLE_W) begin : g_pad
        assign o_sample[SAMPLE_W-1:RES] = '0;
    end

endmodule

// File: rtl/adc_lane_aligner.sv
// Frame-word alignment search: slips all deserializers until the frame clock matches, then locks.
// Samples and valid are registered with 1-cycle latency; bitslip is a 1-cycle pulse from SLIP.
module adc_lane_aligner
    import adc_pkg::*;
#(
    parameter int         N_CH          = 4,
    parameter int         RES           = 14,
    parameter logic [7:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
    parameter int         SETTLE_CYC    = 4,
    parameter int         LOCK_CNT      = 8,
    parameter int         UNLOCK_CNT    = 4,
    parameter int         MAX_SLIPS     = 8
)(
    input  logic                       CLKDIV,
    input  logic                       RST,
    input  logic                       en,
    input  logic [7:0]                 frm_data,
    input  logic [N_CH*8-1:0]          lane0_data,
    input  logic [N_CH*8-1:0]          lane1_data,
    output logic                       bitslip,
    output logic                       aligned,
    output logic                       align_fail,
    output logic [3:0]                 slip_count,
    output logic [N_CH*SAMPLE_W-1:0]   sample_o,
    output logic                       sample_valid
);

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] SLIP_LAST   = 4'(MAX_SLIPS - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [7:0]                 r_match_cnt;
    logic [7:0]                 w_match_nxt;
    logic [7:0]                 r_miss_cnt;
    logic [7:0]                 w_miss_nxt;
    logic [3:0]                 r_settle_cnt;
    logic [3:0]                 w_settle_nxt;
    logic [3:0]                 r_slip_cnt;
    logic [3:0]                 w_slip_nxt;
    logic                       r_align_fail;
    logic                       w_fail_nxt;
    logic                       w_frm_match;
    logic [N_CH*SAMPLE_W-1:0]   w_sample;
    logic [N_CH*SAMPLE_W-1:0]   r_sample;
    logic                       r_sample_valid;

    assign w_frm_match = (frm_data == FRAME_PATTERN);

    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_match_nxt  = r_match_cnt;
        w_miss_nxt   = r_miss_cnt;
        w_settle_nxt = r_settle_cnt;
        w_slip_nxt   = r_slip_cnt;
        w_fail_nxt   = r_align_fail;
        if (!en) begin
            w_state_nxt = IDLE;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
            w_slip_nxt  = '0;
            w_fail_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = CHECK;
                    w_match_nxt = '0;
                end
                CHECK: begin
                    if (!w_frm_match) begin
                        w_match_nxt = '0;
                        w_state_nxt = SLIP;
                    end else if (r_match_cnt == LOCK_LAST) begin
                        w_match_nxt = '0;
                        w_miss_nxt  = '0;
                        w_state_nxt = LOCKED;
                    end else begin
                        w_match_nxt = r_match_cnt + 8'd1;
                    end
                end
                SLIP: begin
                    // Exhausting a pass flags failure but keeps searching from zero.
                    w_settle_nxt = '0;
                    w_state_nxt  = SETTLE;
                    if (r_slip_cnt == SLIP_LAST) begin
                        w_slip_nxt = '0;
                        w_fail_nxt = 1'b1;
                    end else begin
                        w_slip_nxt = r_slip_cnt + 4'd1;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        w_match_nxt = '0;
                        w_state_nxt = CHECK;
                    end else begin
                        w_settle_nxt = r_settle_cnt + 4'd1;
                    end
                end
                LOCKED: begin
                    if (w_frm_match) begin
                        w_miss_nxt = '0;
                    end else if (r_miss_cnt == UNLOCK_LAST) begin
                        w_miss_nxt  = '0;
                        w_match_nxt = '0;
                        w_slip_nxt  = '0;
                        w_state_nxt = CHECK;
                    end else begin
                        w_miss_nxt = r_miss_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) begin
            r_match_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_settle_cnt <= '0;
            r_slip_cnt   <= '0;
            r_align_fail <= 1'b0;
        end else begin
            r_match_cnt  <= w_match_nxt;
            r_miss_cnt   <= w_miss_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_slip_cnt   <= w_slip_nxt;
            r_align_fail <= w_fail_nxt;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        adc_sample_pack #(
            .RES (RES)
        ) u_pack (
            .i_lane0  (lane0_data[c*8 +: 8]),
            .i_lane1  (lane1_data[c*8 +: 8]),
            .o_sample (w_sample[c*SAMPLE_W +: SAMPLE_W])
        );
    end

    // Samples flow every cycle; valid tells the consumer whether lanes were framed.
    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample       <= w_sample;
            r_sample_valid <= (r_state == LOCKED);
        end
    end

    assign bitslip      = (r_state == SLIP);
    assign aligned      = (r_state == LOCKED);
    assign align_fail   = r_align_fail;
    assign slip_count   = r_slip_cnt;
    assign sample_o     = r_sample;
    assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_adc_lane_aligner.sv
// Directed bench for adc_lane_aligner: default-parameter instance plus a 1-channel RES=16 instance.
module tb_adc_lane_aligner;

    logic        CLKDIV;
    logic        RST;
    logic        en;
    logic [7:0]  frm_data;
    logic [31:0] lane0_data;
    logic [31:0] lane1_data;
    logic        bitslip;
    logic        aligned;
    logic        align_fail;
    logic [3:0]  slip_count;
    logic [63:0] sample_o;
    logic        sample_valid;

    logic [7:0]  lane0_16;
    logic [7:0]  lane1_16;
    logic        bitslip_16;
    logic        aligned_16;
    logic        align_fail_16;
    logic [3:0]  slip_count_16;
    logic [15:0] sample_o_16;
    logic        sample_valid_16;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses;

    adc_lane_aligner dut (
        .CLKDIV       (CLKDIV),
        .RST          (RST),
        .en           (en),
        .frm_data     (frm_data),
        .lane0_data   (lane0_data),
        .lane1_data   (lane1_data),
        .bitslip      (bitslip),
        .aligned      (aligned),
        .align_fail   (align_fail),
        .slip_count   (slip_count),
        .sample_o     (sample_o),
        .sample_valid (sample_valid)
    );

    adc_lane_aligner #(
        .N_CH (1),
        .RES  (16)
    ) dut16 (
        .CLKDIV       (CLKDIV),
        .RST          (RST),
        .en           (en),
        .frm_data     (frm_data),
        .lane0_data   (lane0_16),
        .lane1_data   (lane1_16),
        .bitslip      (bitslip_16),
        .aligned      (aligned_16),
        .align_fail   (align_fail_16),
        .slip_count   (slip_count_16),
        .sample_o     (sample_o_16),
        .sample_valid (sample_valid_16)
    );

    initial begin
        CLKDIV = 1'b0;
        forever #5 CLKDIV = ~CLKDIV;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLKDIV);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST        = 1'b1;
        en         = 1'b0;
        frm_data   = 8'h00;
        lane0_data = '0;
        lane1_data = '0;
        lane0_16   = '0;
        lane1_16   = '0;
        tick();
        tick();

        // Reset state
        chk("rst_aligned",      aligned,       0);
        chk("rst_bitslip",      bitslip,       0);
        chk("rst_align_fail",   align_fail,    0);
        chk("rst_slip_count",   slip_count,    0);
        chk("rst_sample_o",     sample_o,      0);
        chk("rst_sample_valid", sample_valid,  0);
        chk("rst16_aligned",    aligned_16,    0);
        chk("rst16_bitslip",    bitslip_16,    0);
        chk("rst16_fail",       align_fail_16, 0);
        chk("rst16_slips",      slip_count_16, 0);
        chk("rst16_sample",     sample_o_16,   0);
        chk("rst16_valid",      sample_valid_16, 0);

        RST = 1'b0;

        // Sample interleave, RES=14 four channels and RES=16 one channel
        lane1_data = 32'h80FF00FF;
        lane0_data = 32'h01FFFF00;
        lane1_16   = 8'hFF;
        lane0_16   = 8'h00;
        tick();
        chk("pack14_vecA",   sample_o,     64'h1000_3FFF_1555_2AAA);
        chk("pack16_vecA",   sample_o_16,  16'hAAAA);
        chk("pack_valid_lo", sample_valid, 0);
        lane1_data = 32'h00000201;
        lane0_data = 32'h00002040;
        lane1_16   = 8'h01;
        lane0_16   = 8'h80;
        tick();
        chk("pack14_vecB", sample_o,    64'h0000_0000_0804_2001);
        chk("pack16_vecB", sample_o_16, 16'h8001);

        // Clean frame: lock after 1 + LOCK_CNT cycles, no slips
        frm_data = 8'hF0;
        en       = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("t1_bitslip", bitslip, 0);
            if (k == 8) chk("t1_aligned_early", aligned, 0);
            if (k == 9) begin
                chk("t1_aligned",     aligned,      1);
                chk("t1_slip_count",  slip_count,   0);
                chk("t1_valid_early", sample_valid, 0);
            end
        end
        tick();
        chk("t1_sample_valid", sample_valid, 1);

        // In lock: 3 misses tolerated, 4 consecutive drop lock
        frm_data = 8'h00;
        for (int m = 1; m <= 3; m++) begin
            tick();
            chk("t4_aligned_3miss", aligned, 1);
        end
        frm_data = 8'hF0;
        tick();
        chk("t4_aligned_recover", aligned, 1);
        frm_data = 8'h00;
        for (int m = 1; m <= 4; m++) begin
            tick();
            chk("t4_bitslip", bitslip, 0);
            if (m == 3) chk("t4_aligned_m3", aligned, 1);
            if (m == 4) begin
                chk("t4_aligned_drop", aligned,      0);
                chk("t4_slip_count",   slip_count,   0);
                chk("t4_valid_lag",    sample_valid, 1);
            end
        end
        en = 1'b0;
        tick();
        chk("t4_valid_off", sample_valid, 0);
        chk("t4_idle_slip", bitslip,      0);

        // Two slips needed before the frame word matches
        frm_data = 8'hE1;
        en       = 1'b1;
        pulses   = 0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            chk("t2_bitslip", bitslip, (k == 2 || k == 8) ? 1 : 0);
            if (bitslip === 1'b1) pulses++;
            if (k == 3)  chk("t2_slip_count1", slip_count, 1);
            if (k == 8)  frm_data = 8'hF0;
            if (k == 9)  chk("t2_slip_count2", slip_count, 2);
            if (k == 20) chk("t2_aligned_early", aligned, 0);
            if (k == 21) chk("t2_aligned", aligned, 1);
        end
        chk("t2_pulse_total", pulses, 2);

        // Never-matching frame: fail flag after pass of 8 slips, search continues
        en = 1'b0;
        tick();
        chk("t3_clr_aligned", aligned,    0);
        chk("t3_clr_slips",   slip_count, 0);
        frm_data = 8'h00;
        en       = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            tick();
            chk("t3_bitslip", bitslip,
                (k >= 2 && k <= 50 && (k - 2) % 6 == 0) ? 1 : 0);
            if (k == 44) begin
                chk("t3_slip_count7", slip_count, 7);
                chk("t3_fail_before", align_fail, 0);
            end
            if (k == 45) begin
                chk("t3_slip_wrap", slip_count, 0);
                chk("t3_fail_set",  align_fail, 1);
            end
            if (k == 51) begin
                chk("t3_slip_after_wrap", slip_count, 1);
                frm_data = 8'hF0;
            end
            if (k == 62) chk("t3_aligned_early", aligned, 0);
            if (k == 63) begin
                chk("t3_aligned",      aligned,    1);
                chk("t3_fail_sticky",  align_fail, 1);
            end
        end
        en = 1'b0;
        tick();
        chk("t3_fail_clear", align_fail, 0);
        chk("t3_aligned_off", aligned,   0);

        // Asynchronous reset while locked
        en         = 1'b1;
        lane1_data = 32'h80FF00FF;
        lane0_data = 32'h01FFFF00;
        for (int k = 1; k <= 10; k++) tick();
        chk("t5_locked",    aligned,      1);
        chk("t5_valid",     sample_valid, 1);
        chk("t5_sample_nz", sample_o,     64'h1000_3FFF_1555_2AAA);
        #3;
        RST = 1'b1;
        #1;
        chk("t5_async_aligned", aligned,      0);
        chk("t5_async_valid",   sample_valid, 0);
        chk("t5_async_sample",  sample_o,     0);
        chk("t5_async_bitslip", bitslip,      0);
        tick();
        RST      = 1'b0;
        frm_data = 8'h00;
        tick();
        chk("t5_release_noslip", bitslip, 0);
        chk("t5_release_unlock", aligned, 0);
        tick();
        chk("t5_search_slip", bitslip, 1);
        en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
